sdram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single SDRAM controller read/write request interface among NUM_PORTS client requesters.
- Sits between clients (frame buffer, CPU bridge, DMA) and the controller's iwrite_req/iread_req/ack handshake.
- Serialises transactions, returns read data and acks to the owning port, and recovers from a missing ack with a timeout error.

---
 rtl/sdram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller read/write request
// interface among NUM_PORTS clients, with a per-transaction ack timeout.
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int PW            = $clog2(NUM_PORTS),
    localparam int CW            = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                        iclk,
    input  logic                        ireset_n,
    input  logic [NUM_PORTS-1:0]        ireq,
    input  logic [NUM_PORTS-1:0]        iwe,
    input  logic [NUM_PORTS*ADDR_W-1:0] iaddr,
    input  logic [NUM_PORTS*DATA_W-1:0] iwdata,
    output logic [NUM_PORTS-1:0]        oack,
    output logic                        oerr,
    output logic [DATA_W-1:0]           ordata,
    output logic [PW-1:0]               ogrant,
    output logic                        obusy,
    output logic                        owrite_req,
    output logic [ADDR_W-1:0]           owrite_address,
    output logic [DATA_W-1:0]           owrite_data,
    input  logic                        iwrite_ack,
    output logic                        oread_req,
    output logic [ADDR_W-1:0]           oread_address,
    input  logic [DATA_W-1:0]           iread_data,
    input  logic                        iread_ack
);

    typedef enum logic [1:0] {ARB, ISSUE, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [NUM_PORTS-1:0]  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  wreq_q, wreq_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rreq_q, rreq_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;

    logic                  found;
    int                    win;
    logic                  ack_match;
    logic [PW-1:0]         ptr_next;

    // Rotating priority scan: first requester at or above the pointer wins.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_PORTS;
            if (!found && ireq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ack_match = (wreq_q && iwrite_ack) || (rreq_q && iread_ack);
    assign ptr_next  = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        wreq_d  = wreq_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rreq_d  = rreq_q;
        raddr_d = raddr_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d = PW'(win);
                    if (iwe[win]) begin
                        wreq_d  = 1'b1;
                        waddr_d = iaddr[win*ADDR_W +: ADDR_W];
                        wdata_d = iwdata[win*DATA_W +: DATA_W];
                    end else begin
                        rreq_d  = 1'b1;
                        raddr_d = iaddr[win*ADDR_W +: ADDR_W];
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_match || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // A matching ack takes precedence over a timeout on the same cycle.
                    wreq_d  = 1'b0;
                    rreq_d  = 1'b0;
                    ack_d   = NUM_PORTS'(1) << grant_q;
                    err_d   = !ack_match;
                    if (ack_match && rreq_q) begin
                        rdata_d = iread_data;
                    end
                    ptr_d   = ptr_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ack_d   = '0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rreq_q  <= 1'b0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            wreq_q  <= wreq_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rreq_q  <= rreq_d;
            raddr_q <= raddr_d;
        end
    end

    assign oack           = ack_q;
    assign oerr           = err_q;
    assign ordata         = rdata_q;
    assign ogrant         = grant_q;
    assign obusy          = busy_q;
    assign owrite_req     = wreq_q;
    assign owrite_address = waddr_q;
    assign owrite_data    = wdata_q;
    assign oread_req      = rreq_q;
    assign oread_address  = raddr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: expected transactions are queued when
// stimulus is driven and checked when the arbiter issues and acknowledges them.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              iclk = 1'b0;
    logic              ireset_n;
    logic [NP-1:0]     ireq;
    logic [NP-1:0]     iwe;
    logic [NP*AW-1:0]  iaddr;
    logic [NP*DW-1:0]  iwdata;
    logic [NP-1:0]     oack;
    logic              oerr;
    logic [DW-1:0]     ordata;
    logic [1:0]        ogrant;
    logic              obusy;
    logic              owrite_req;
    logic [AW-1:0]     owrite_address;
    logic [DW-1:0]     owrite_data;
    logic              iwrite_ack;
    logic              oread_req;
    logic [AW-1:0]     oread_address;
    logic [DW-1:0]     iread_data;
    logic              iread_ack;

    sdram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq), .iwe(iwe),
        .iaddr(iaddr), .iwdata(iwdata), .oack(oack), .oerr(oerr),
        .ordata(ordata), .ogrant(ogrant), .obusy(obusy),
        .owrite_req(owrite_req), .owrite_address(owrite_address),
        .owrite_data(owrite_data), .iwrite_ack(iwrite_ack),
        .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int          port;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        bit          err;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            done_cyc = -100;
    bit            check_gap = 0;
    logic [DW-1:0] ordata_model = '0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iwe[p]            = we;
        iaddr[p*AW +: AW] = a;
        iwdata[p*DW +: DW] = d;
    endtask

    task automatic push(input int p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd, input bit err);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.wd = d; e.rd = rd; e.err = err;
        sb.push_back(e);
    endtask

    // ack_cycle = 0 means withhold the ack; spurious pulses the opposite ack on ISSUE cycle 2.
    task automatic run_txn(input int ack_cycle, input logic [DW-1:0] rd, input bit spurious);
        exp_t e;
        int   n;
        int   issue;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb[0];
        n = 0;
        while (!(owrite_req || oread_req) && n < 20) begin
            @(negedge iclk);
            n++;
        end
        chk("req_seen", (n < 20), 1);
        if (check_gap) chk("req_gap_ge2", ((cyc - done_cyc) >= 2), 1);
        chk("grant", ogrant, e.port);
        chk("write_req", owrite_req, e.we);
        chk("read_req", oread_req, !e.we);
        chk("busy_issue", obusy, 1);
        if (e.we) begin
            chk("write_addr", owrite_address, e.addr);
            chk("write_data", owrite_data, e.wd);
        end else begin
            chk("read_addr", oread_address, e.addr);
        end
        issue = 1;
        if (ack_cycle > 0) begin
            while (issue < ack_cycle) begin
                if (spurious && issue == 2) begin
                    if (e.we) iread_ack = 1'b1; else iwrite_ack = 1'b1;
                end
                @(negedge iclk);
                iread_ack = 1'b0; iwrite_ack = 1'b0;
                issue++;
            end
            if (e.we) iwrite_ack = 1'b1;
            else begin
                iread_ack  = 1'b1;
                iread_data = rd;
            end
            @(negedge iclk);
            iwrite_ack = 1'b0; iread_ack = 1'b0;
            iread_data = DW'($urandom);
        end else begin
            while ((owrite_req || oread_req) && issue < 40) begin
                if (spurious && issue == 2) begin
                    if (e.we) iread_ack = 1'b1; else iwrite_ack = 1'b1;
                end
                @(negedge iclk);
                iread_ack = 1'b0; iwrite_ack = 1'b0;
                if (owrite_req || oread_req) issue++;
            end
            chk("timeout_issue_cycles", issue, TO);
        end
        if (!e.we && !e.err) ordata_model = e.rd;
        chk("ack_onehot", oack, NP'(1) << e.port);
        chk("err", oerr, e.err);
        chk("rdata", ordata, ordata_model);
        chk("write_req_dropped", owrite_req, 0);
        chk("read_req_dropped", oread_req, 0);
        chk("busy_done", obusy, 1);
        $display("txn port=%0d we=%0d addr=%06h ack=%b err=%0d rdata=%04h",
                 e.port, e.we, e.addr, oack, oerr, ordata);
        done_cyc = cyc;
        void'(sb.pop_front());
        @(negedge iclk);
        chk("ack_cleared", oack, 0);
        chk("err_cleared", oerr, 0);
        chk("busy_cleared", obusy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs"}, {oack, oerr, ogrant, obusy, owrite_req, oread_req}, 0);
        chk({tag, "_data"}, {ordata, owrite_address, owrite_data, oread_address}, 0);
    endtask

    initial begin
        ireset_n = 1'b0;
        ireq = '0; iwe = '0; iaddr = '0; iwdata = '0;
        iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;
        repeat (3) @(negedge iclk);
        check_zero("reset");
        ireset_n = 1'b1;
        @(negedge iclk);
        check_zero("idle");

        // Write on port 0, ack on ISSUE cycle 5.
        set_port(0, 1, 22'h001234, 16'hBEEF);
        push(0, 1, 22'h001234, 16'hBEEF, '0, 0);
        ireq = 4'b0001;
        run_txn(5, '0, 0);
        ireq = '0;

        // Read on port 2, spurious write ack ignored.
        set_port(2, 0, 22'h3F0001, 16'h0000);
        push(2, 0, 22'h3F0001, '0, 16'hA5A5, 0);
        ireq = 4'b0100;
        run_txn(3, 16'hA5A5, 1);
        ireq = '0;

        // Pointer is now 3: port 3 before port 0.
        set_port(3, 0, 22'h2AAAA5, 16'h0000);
        set_port(0, 1, 22'h000777, 16'h1357);
        push(3, 0, 22'h2AAAA5, '0, 16'h5A5A, 0);
        push(0, 1, 22'h000777, 16'h1357, '0, 0);
        ireq = 4'b1001;
        run_txn(1, 16'h5A5A, 0);
        ireq = 4'b0001;
        run_txn(2, '0, 0);
        ireq = '0;

        // Timeout on a write to port 1 with a stray read ack.
        set_port(1, 1, 22'h155555, 16'hC0DE);
        push(1, 1, 22'h155555, 16'hC0DE, '0, 1);
        ireq = 4'b0010;
        run_txn(0, '0, 1);
        ireq = '0;

        // Fairness from reset: 0,1,2,3,0 with all ports asserting.
        ireset_n = 1'b0;
        @(negedge iclk);
        ireset_n = 1'b1;
        ordata_model = '0;
        set_port(0, 1, 22'h000010, 16'h0010);
        set_port(1, 0, 22'h000011, 16'h0000);
        set_port(2, 1, 22'h000012, 16'h0012);
        set_port(3, 0, 22'h000013, 16'h0000);
        push(0, 1, 22'h000010, 16'h0010, '0, 0);
        push(1, 0, 22'h000011, '0, 16'h1111, 0);
        push(2, 1, 22'h000012, 16'h0012, '0, 0);
        push(3, 0, 22'h000013, '0, 16'h3333, 0);
        push(0, 1, 22'h000010, 16'h0010, '0, 0);
        ireq = 4'b1111;
        run_txn(1, '0, 0);
        check_gap = 1;
        run_txn(2, 16'h1111, 0);
        run_txn(1, '0, 0);
        run_txn(4, 16'h3333, 0);
        @(posedge iclk);
        #1 ireq = '0;
        run_txn(2, '0, 0);
        check_gap = 0;

        // Reset mid-ISSUE with pointer at 1: port 3 first, then port 0 after reset.
        set_port(3, 1, 22'h0ABCDE, 16'hFACE);
        set_port(0, 1, 22'h012345, 16'h6789);
        ireq = 4'b1001;
        repeat (2) @(negedge iclk);
        chk("pre_reset_grant", ogrant, 3);
        chk("pre_reset_req", owrite_req, 1);
        @(negedge iclk);
        ireset_n = 1'b0;
        #1;
        check_zero("async_reset");
        ordata_model = '0;
        repeat (2) begin
            @(negedge iclk);
            chk("no_ack_in_reset", oack, 0);
        end
        ireset_n = 1'b1;
        push(0, 1, 22'h012345, 16'h6789, '0, 0);
        run_txn(3, '0, 0);
        ireq = '0;
        repeat (3) @(negedge iclk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
